// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the memory-side arbiter.
// Holds the line type and the arbiter state/grant encodings.
package lc3b_types;

   typedef logic [127:0] lc3b_line;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY_I,
      ARB_BUSY_D,
      ARB_RECOVER
   } arb_state_t;

   typedef enum logic [1:0] {
      GRANT_NONE,
      GRANT_I,
      GRANT_D
   } arb_grant_t;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational winner select between I-cache and D-cache requests.
// CACHE_ARB_ROUND_ROBIN_EN: alternate on contention instead of D priority.
module arb_grant_sel
   import lc3b_types::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       i_req_i,
   input  logic       d_req_i,
`ifdef CACHE_ARB_ROUND_ROBIN_EN
   input  arb_grant_t last_grant_i,
`else
   input  logic [3:0] starve_cnt_i,
`endif
   output arb_grant_t grant_o
);

`ifndef CACHE_ARB_ROUND_ROBIN_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
`endif

   // Pick the winner; contention resolved by priority policy
   always_comb begin
      grant_o = GRANT_NONE;
      if (i_req_i && d_req_i) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
         grant_o = (last_grant_i == GRANT_D) ? GRANT_I : GRANT_D;
`else
         grant_o = (starve_cnt_i == LIMIT) ? GRANT_I : GRANT_D;
`endif
      end else if (d_req_i) begin
         grant_o = GRANT_D;
      end else if (i_req_i) begin
         grant_o = GRANT_I;
      end
   end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache.
// CACHE_ARB_ROUND_ROBIN_EN: alternating priority replaces D priority.
module cache_arbiter
   import lc3b_types::*;
#(
   parameter int LINE_W       = 128,
   parameter int ADDR_W       = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] i_pmem_address,
   input  logic              i_pmem_read,
   output logic [LINE_W-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,
   input  logic [ADDR_W-1:0] d_pmem_address,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [LINE_W-1:0] d_pmem_wdata,
   output logic [LINE_W-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,
   output logic [ADDR_W-1:0] pmem_address,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   arb_state_t        state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic              rd_q;
   logic              wr_q;
   logic              d_req;
   arb_grant_t        grant;

   assign d_req = d_pmem_read | d_pmem_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
   arb_grant_t last_grant_q;
   arb_grant_t last_grant_d;

   arb_grant_sel #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_sel (
      .i_req_i      (i_pmem_read),
      .d_req_i      (d_req),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   // Remember which side won the most recent grant
   always_comb begin
      last_grant_d = last_grant_q;
      if (state_q == ARB_IDLE && grant != GRANT_NONE)
         last_grant_d = grant;
   end

   // Last-grant flop; starts at I so first contention goes to D
   always_ff @(posedge clk or posedge reset) begin
      if (reset) last_grant_q <= GRANT_I;
      else       last_grant_q <= last_grant_d;
   end
`else
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt_q;
   logic [3:0] starve_cnt_d;

   arb_grant_sel #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_sel (
      .i_req_i      (i_pmem_read),
      .d_req_i      (d_req),
      .starve_cnt_i (starve_cnt_q),
      .grant_o      (grant)
   );

   // Count D grants that bypass a waiting I request
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (state_q == ARB_IDLE) begin
         if (grant == GRANT_I) begin
            starve_cnt_d = '0;
         end else if (grant == GRANT_D) begin
            if (!i_pmem_read)
               starve_cnt_d = '0;
            else if (starve_cnt_q != LIMIT)
               starve_cnt_d = starve_cnt_q + 4'd1;
         end
      end
   end

   // Starvation counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) starve_cnt_q <= '0;
      else       starve_cnt_q <= starve_cnt_d;
   end
`endif

   // Transaction FSM: latch winner, hold strobe until resp, one dead cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         unique case (state_q)
            ARB_IDLE: begin
               if (grant == GRANT_D) begin
                  state_q <= ARB_BUSY_D;
                  addr_q  <= d_pmem_address;
                  wr_q    <= d_pmem_write;
                  rd_q    <= ~d_pmem_write;
                  if (d_pmem_write)
                     wdata_q <= d_pmem_wdata;
               end else if (grant == GRANT_I) begin
                  state_q <= ARB_BUSY_I;
                  addr_q  <= i_pmem_address;
                  rd_q    <= 1'b1;
                  wr_q    <= 1'b0;
               end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
               if (pmem_resp) begin
                  state_q <= ARB_RECOVER;
                  rd_q    <= 1'b0;
                  wr_q    <= 1'b0;
               end
            end
            ARB_RECOVER: state_q <= ARB_IDLE;
            default:     state_q <= ARB_IDLE;
         endcase
      end
   end

   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign pmem_read    = rd_q;
   assign pmem_write   = wr_q;

   assign i_pmem_resp  = (state_q == ARB_BUSY_I) & pmem_resp;
   assign d_pmem_resp  = (state_q == ARB_BUSY_D) & pmem_resp;
   assign i_pmem_rdata = (state_q == ARB_BUSY_I) ? pmem_rdata : '0;
   assign d_pmem_rdata = (state_q == ARB_BUSY_D) ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter with a fixed-latency memory model.
// Build with CACHE_ARB_ROUND_ROBIN_EN to check alternating priority.
module tb_cache_arbiter;
   import lc3b_types::*;

   localparam int LAT = 3;

   logic         clk = 1'b0;
   logic         reset;
   logic [15:0]  i_pmem_address;
   logic         i_pmem_read;
   logic [127:0] i_pmem_rdata;
   logic         i_pmem_resp;
   logic [15:0]  d_pmem_address;
   logic         d_pmem_read;
   logic         d_pmem_write;
   logic [127:0] d_pmem_wdata;
   logic [127:0] d_pmem_rdata;
   logic         d_pmem_resp;
   logic [15:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   logic auto_resp = 1'b0;
   logic force_resp;
   int   mem_cnt = 0;

   typedef struct {
      logic         is_d;
      logic         wr;
      logic [15:0]  addr;
      logic [127:0] wdata;
   } txn_t;

   txn_t sb[$];
   int   n_total = 0;
   int   n_pass  = 0;

   cache_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .i_pmem_address (i_pmem_address),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_rdata   (i_pmem_rdata),
      .i_pmem_resp    (i_pmem_resp),
      .d_pmem_address (d_pmem_address),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_rdata   (d_pmem_rdata),
      .d_pmem_resp    (d_pmem_resp),
      .pmem_address   (pmem_address),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_wdata     (pmem_wdata),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp)
   );

   always #10 clk = ~clk;

   function automatic logic [127:0] exp_rdata(input logic [15:0] a);
      if (a == 16'h1230) return {16{8'hA5}};
      return {8{a}};
   endfunction

   assign pmem_resp  = auto_resp | force_resp;
   assign pmem_rdata = pmem_resp ? exp_rdata(pmem_address) : '0;

   // Memory: answer LAT cycles after a strobe rises
   always @(negedge clk) begin
      if (pmem_read || pmem_write) begin
         mem_cnt   = mem_cnt + 1;
         auto_resp = (mem_cnt == LAT);
      end else begin
         mem_cnt   = 0;
         auto_resp = 1'b0;
      end
   end

   task automatic expect_txn(input logic d, input logic w,
                             input logic [15:0] a,
                             input logic [127:0] wd);
      txn_t t;
      t.is_d  = d;
      t.wr    = w;
      t.addr  = a;
      t.wdata = wd;
      sb.push_back(t);
   endtask

   // Drain n responses against the scoreboard; count strobe cycles
   task automatic wait_resps(input int n, output int strobes);
      int got;
      txn_t e;
      logic [127:0] rd;
      logic [127:0] other;
      got = 0;
      strobes = 0;
      for (int c = 0; c < 300 && got < n; c++) begin
         @(negedge clk);
         #3;
         if (pmem_read || pmem_write) strobes++;
         if (i_pmem_resp || d_pmem_resp) begin
            got++;
            n_total++;
            if (i_pmem_resp && d_pmem_resp)
               $display("FAIL both_resp i=%0b d=%0b required one", i_pmem_resp, d_pmem_resp);
            else n_pass++;
            n_total++;
            if (sb.size() == 0) begin
               $display("FAIL unexpected_resp i=%0b d=%0b required none", i_pmem_resp, d_pmem_resp);
            end else begin
               n_pass++;
               e = sb.pop_front();
               n_total++;
               if (d_pmem_resp !== e.is_d)
                  $display("FAIL grant_side got_d=%0b required_d=%0b", d_pmem_resp, e.is_d);
               else n_pass++;
               n_total++;
               if (pmem_address !== e.addr)
                  $display("FAIL pmem_address got=%h required=%h", pmem_address, e.addr);
               else n_pass++;
               n_total++;
               if (pmem_write !== e.wr || pmem_read !== !e.wr)
                  $display("FAIL pmem_op got rd=%0b wr=%0b required wr=%0b", pmem_read, pmem_write, e.wr);
               else n_pass++;
               if (e.wr) begin
                  n_total++;
                  if (pmem_wdata !== e.wdata)
                     $display("FAIL pmem_wdata got=%h required=%h", pmem_wdata, e.wdata);
                  else n_pass++;
               end
               rd    = e.is_d ? d_pmem_rdata : i_pmem_rdata;
               other = e.is_d ? i_pmem_rdata : d_pmem_rdata;
               n_total++;
               if (rd !== exp_rdata(e.addr))
                  $display("FAIL resp_rdata got=%h required=%h", rd, exp_rdata(e.addr));
               else n_pass++;
               n_total++;
               if (other !== '0)
                  $display("FAIL other_rdata got=%h required=0", other);
               else n_pass++;
            end
         end
      end
      n_total++;
      if (got != n) $display("FAIL resp_timeout got=%0d required=%0d", got, n);
      else n_pass++;
   endtask

   task automatic idle_inputs();
      i_pmem_address = '0;
      i_pmem_read    = 1'b0;
      d_pmem_address = '0;
      d_pmem_read    = 1'b0;
      d_pmem_write   = 1'b0;
      d_pmem_wdata   = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #3;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #3;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      force_resp = 1'b0;
      reset = 1'b1;
      #1;
      n_total++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0)
         $display("FAIL rst_strobes got rd=%0b wr=%0b required 0", pmem_read, pmem_write);
      else n_pass++;
      n_total++;
      if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0)
         $display("FAIL rst_resp got i=%0b d=%0b required 0", i_pmem_resp, d_pmem_resp);
      else n_pass++;
      n_total++;
      if (pmem_address !== '0 || pmem_wdata !== '0)
         $display("FAIL rst_hold got a=%h wd=%h required 0", pmem_address, pmem_wdata);
      else n_pass++;
      n_total++;
      if (i_pmem_rdata !== '0 || d_pmem_rdata !== '0)
         $display("FAIL rst_rdata got i=%h d=%h required 0", i_pmem_rdata, d_pmem_rdata);
      else n_pass++;
      n_total++;
      if (dut.state_q !== ARB_IDLE)
         $display("FAIL rst_state got=%0d required=%0d", dut.state_q, ARB_IDLE);
      else n_pass++;
      repeat (2) @(negedge clk);
      #3;
      reset = 1'b0;
   endtask

   task automatic test_i_read();
      int s;
      repeat (2) @(negedge clk);
      #3;
      expect_txn(1'b0, 1'b0, 16'h1230, '0);
      i_pmem_address = 16'h1230;
      i_pmem_read    = 1'b1;
      n_total++;
      if (pmem_read !== 1'b0)
         $display("FAIL i_pre_strobe got=%0b required=0", pmem_read);
      else n_pass++;
      @(posedge clk);
      #1;
      n_total++;
      if (pmem_read !== 1'b1 || pmem_address !== 16'h1230)
         $display("FAIL i_latency got rd=%0b a=%h required rd=1 a=1230", pmem_read, pmem_address);
      else n_pass++;
      wait_resps(1, s);
      i_pmem_read = 1'b0;
      n_total++;
      if (s != LAT) $display("FAIL i_strobe_len got=%0d required=%0d", s, LAT);
      else n_pass++;
      @(posedge clk);
      #1;
      n_total++;
      if (dut.state_q !== ARB_RECOVER || pmem_read !== 1'b0 || i_pmem_resp !== 1'b0)
         $display("FAIL i_recover got st=%0d rd=%0b resp=%0b required st=3 rd=0 resp=0", dut.state_q, pmem_read, i_pmem_resp);
      else n_pass++;
      n_total++;
      if (i_pmem_rdata !== '0)
         $display("FAIL i_rdata_idle got=%h required=0", i_pmem_rdata);
      else n_pass++;
      @(posedge clk);
      #1;
      n_total++;
      if (dut.state_q !== ARB_IDLE)
         $display("FAIL i_back_idle got=%0d required=%0d", dut.state_q, ARB_IDLE);
      else n_pass++;
   endtask

   task automatic test_contention();
      int s;
      repeat (2) @(negedge clk);
      #3;
      expect_txn(1'b1, 1'b1, 16'h4000, {32{4'h1}});
      expect_txn(1'b0, 1'b0, 16'h2340, '0);
      i_pmem_address = 16'h2340;
      i_pmem_read    = 1'b1;
      d_pmem_address = 16'h4000;
      d_pmem_wdata   = {32{4'h1}};
      d_pmem_write   = 1'b1;
      wait_resps(1, s);
      d_pmem_write = 1'b0;
      wait_resps(1, s);
      i_pmem_read = 1'b0;
   endtask

   task automatic test_starvation();
      int s;
      int n;
      repeat (2) @(negedge clk);
      #3;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      n = 2;
      expect_txn(1'b1, 1'b0, 16'h5000, '0);
`else
      n = 5;
      for (int k = 0; k < 4; k++) expect_txn(1'b1, 1'b0, 16'h5000, '0);
`endif
      expect_txn(1'b0, 1'b0, 16'h2000, '0);
      i_pmem_address = 16'h2000;
      i_pmem_read    = 1'b1;
      d_pmem_address = 16'h5000;
      d_pmem_read    = 1'b1;
      wait_resps(n, s);
      i_pmem_read = 1'b0;
      d_pmem_read = 1'b0;
`ifndef CACHE_ARB_ROUND_ROBIN_EN
      n_total++;
      if (dut.starve_cnt_q !== 4'd0)
         $display("FAIL starve_clear got=%0d required=0", dut.starve_cnt_q);
      else n_pass++;
`endif
   endtask

   task automatic test_rw_together();
      int s;
      repeat (2) @(negedge clk);
      #3;
      expect_txn(1'b1, 1'b1, 16'h4100, {4{32'hDEADBEEF}});
      expect_txn(1'b1, 1'b0, 16'h4100, '0);
      d_pmem_address = 16'h4100;
      d_pmem_wdata   = {4{32'hDEADBEEF}};
      d_pmem_read    = 1'b1;
      d_pmem_write   = 1'b1;
      wait_resps(1, s);
      d_pmem_write = 1'b0;
      wait_resps(1, s);
      d_pmem_read = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #3;
         n_total++;
         if (d_pmem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0)
            $display("FAIL rw_extra got resp=%0b rd=%0b wr=%0b required 0", d_pmem_resp, pmem_read, pmem_write);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_busy();
      repeat (2) @(negedge clk);
      #3;
      d_pmem_address = 16'h4200;
      d_pmem_wdata   = {8{16'hBEEF}};
      d_pmem_write   = 1'b1;
      @(posedge clk);
      #1;
      n_total++;
      if (pmem_write !== 1'b1 || dut.state_q !== ARB_BUSY_D)
         $display("FAIL busy_d got wr=%0b st=%0d required wr=1 st=2", pmem_write, dut.state_q);
      else n_pass++;
      #2;
      force_resp = 1'b1;
      #1;
      n_total++;
      if (d_pmem_resp !== 1'b1)
         $display("FAIL busy_resp got=%0b required=1", d_pmem_resp);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_total++;
      if (pmem_write !== 1'b0 || d_pmem_resp !== 1'b0)
         $display("FAIL rst_mid got wr=%0b resp=%0b required 0", pmem_write, d_pmem_resp);
      else n_pass++;
      n_total++;
      if (dut.state_q !== ARB_IDLE)
         $display("FAIL rst_mid_state got=%0d required=%0d", dut.state_q, ARB_IDLE);
      else n_pass++;
      d_pmem_write = 1'b0;
      @(negedge clk);
      #3;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         n_total++;
         if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0 || dut.state_q !== ARB_IDLE)
            $display("FAIL stray_resp got i=%0b d=%0b st=%0d required 0 0 0", i_pmem_resp, d_pmem_resp, dut.state_q);
         else n_pass++;
      end
      force_resp = 1'b0;
   endtask

   task automatic test_back_to_back();
      int s;
      apply_reset();
      #0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      expect_txn(1'b1, 1'b0, 16'h6000, '0);
      expect_txn(1'b0, 1'b0, 16'h7000, '0);
      expect_txn(1'b1, 1'b0, 16'h6000, '0);
      expect_txn(1'b0, 1'b0, 16'h7000, '0);
`else
      for (int k = 0; k < 4; k++) expect_txn(1'b1, 1'b0, 16'h6000, '0);
`endif
      i_pmem_address = 16'h7000;
      i_pmem_read    = 1'b1;
      d_pmem_address = 16'h6000;
      d_pmem_read    = 1'b1;
      wait_resps(4, s);
      i_pmem_read = 1'b0;
      d_pmem_read = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if (sb.size() != 0)
         $display("FAIL sb_leftover got=%0d required=0", sb.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_i_read();
      test_contention();
      test_starvation();
      test_rw_together();
      test_reset_mid_busy();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory port between the I-cache miss path and the D-cache miss/writeback path of the LC-3b pipeline.
- Sits between the two cache controllers and physical memory.
- Serialises line transfers and latches the winning request for the whole transaction.
- Returns a one-cycle response pulse to the requester that won.

Parameters:
- LINE_W, 128, cache line width in bits.
- ADDR_W, 16, byte address width.
- STARVE_LIMIT, 4, consecutive D grants allowed while I is pending before I is forced; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- i_pmem_address  in  ADDR_W  I-cache line address.
- i_pmem_read  in  1  I-cache line-read request, level.
- i_pmem_rdata  out  LINE_W  line returned to I-cache.
- i_pmem_resp  out  1  I transaction complete, one-cycle pulse.
- d_pmem_address  in  ADDR_W  D-cache line address.
- d_pmem_read  in  1  D-cache line-read request, level.
- d_pmem_write  in  1  D-cache writeback request, level.
- d_pmem_wdata  in  LINE_W  writeback line.
- d_pmem_rdata  out  LINE_W  line returned to D-cache.
- d_pmem_resp  out  1  D transaction complete, one-cycle pulse.
- pmem_address  out  ADDR_W  physical memory address.
- pmem_read  out  1  physical read strobe.
- pmem_write  out  1  physical write strobe.
- pmem_wdata  out  LINE_W  physical write data.
- pmem_rdata  in  LINE_W  physical read data.
- pmem_resp  in  1  physical transaction done.

Behaviour:
- States:
  - IDLE: sample requests.
  - BUSY_I: serving I.
  - BUSY_D: serving D.
  - RECOVER: one dead cycle after every completion so a requester still holding its level in the resp cycle is not regranted.
- IDLE:
  - A D request (read or write) plus an I request → grant D, unless starve_cnt == STARVE_LIMIT, in which case grant I.
  - A single requester → grant it.
  - No request → stay in IDLE.
- At grant:
  - Latch address, op, and for D writes the wdata into holding registers.
  - pmem_* driven from these registers starting the next cycle.
  - Latency from request to first pmem strobe is 1 cycle.
- Read and write both asserted on D: treat as write (writeback precedes refill). Read is serviced in a later grant if still asserted.
- BUSY_x:
  - Hold pmem_read or pmem_write high until pmem_resp.
  - On pmem_resp: x_pmem_resp = 1 for exactly that cycle, x_pmem_rdata = pmem_rdata combinationally; the other side's resp stays 0.
  - Then go to RECOVER.
  - Requests from the other side arriving during BUSY are ignored until IDLE.
- RECOVER: all strobes 0, no grant; go to IDLE next cycle.
- starve_cnt (4 bits):
  - Increments on a D grant while i_pmem_read = 1.
  - Clears on an I grant, or on a D grant with I idle.
  - Saturates at STARVE_LIMIT.
- Outputs:
  - x_pmem_rdata is pmem_rdata muxed by the current grant; 0 when neither side is being served.
  - pmem_address/pmem_wdata hold their last latched value when idle.
- Reset (async, any state including mid-transaction):
  - State = IDLE; starve_cnt = 0; holding registers = 0.
  - pmem_read, pmem_write, i_pmem_resp and d_pmem_resp all = 0 immediately.
  - A pmem_resp arriving while in IDLE or RECOVER is ignored.

Optional Feature:
- Macro CACHE_ARB_ROUND_ROBIN_EN.
- Defined:
  - Fixed D priority is replaced by alternating priority: a last_grant flop gives the contending winner to the side not granted last.
  - starve_cnt and STARVE_LIMIT are unused and must synthesize away.
  - last_grant resets to I, so the first contention goes to D.
- Undefined: D priority with the starvation limit, as described above.

Decomposition:
- Add to lc3b_types:
  - typedef lc3b_line (logic [127:0]).
  - enum arb_state_t {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D, ARB_RECOVER}.
  - enum arb_grant_t {GRANT_NONE, GRANT_I, GRANT_D}.
- One sub-module, arb_grant_sel: purely combinational winner select.
  - Inputs: the requests, starve_cnt or last_grant.
  - Output: an arb_grant_t.
- The FSM, counters and holding registers stay in cache_arbiter.

Test Plan:
1. I read alone, addr 0x1230, pmem_resp after 3 cycles with rdata = 0xA5..A5
   → pmem_read high 1 cycle after request, for 3 cycles.
   → i_pmem_resp pulses once with i_pmem_rdata = 0xA5..A5.
   → d_pmem_resp stays 0; then 1 RECOVER cycle.
2. I read and D write (addr 0x4000, wdata = 0x1..) in the same cycle
   → D granted first: pmem_write, pmem_address = 0x4000.
   → After d_pmem_resp and RECOVER, I granted with pmem_address = I address.
3. D requests continuously (STARVE_LIMIT = 4) with I held pending
   → exactly 4 D transactions, then an I grant, then starve_cnt = 0.
4. D asserts read and write together
   → write serviced first; after RECOVER the still-held read is serviced.
   → Two d_pmem_resp pulses in total.
5. reset asserted mid BUSY_D
   → pmem_write and d_pmem_resp drop in the same cycle; state IDLE.
   → A pmem_resp arriving afterwards produces no response pulse.
6. With CACHE_ARB_ROUND_ROBIN_EN, four back-to-back contended rounds
   → grants in the order D, I, D, I.
